ncl_prod_collector: RTL and testbench

Clocked collector that sits directly downstream of the NCL_MULT3 dual-rail multiplier. It consumes the six dual-rail product bits, drives the multiplier's Ki acknowledge, detects DATA and NULL wavefronts, and decodes each DATA wavefront into a 6-bit binary product. Decoded products are pushed into a small FIFO and presented on a valid/ready interface to the synchronous side of the design.

---
 rtl/ncl_prod_collector_if.sv | 30 +++
 rtl/ncl_prod_collector.sv | 143 ++++++++++++++
 tb/tb_ncl_prod_collector.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ncl_prod_collector_if.sv
// Bundle of dual-rail product rails, the Ki acknowledge and the
// valid/ready product output of ncl_prod_collector.
interface ncl_prod_collector_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic Po0_rail1, Po1_rail1, Po2_rail1, Po3_rail1, Po4_rail1, Po5_rail1;
    logic Po0_rail0, Po1_rail0, Po2_rail0, Po3_rail0, Po4_rail0, Po5_rail0;
    logic          Ki;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    out_data;
    logic          err_illegal;
    logic [LW-1:0] level;

    modport master (
        input  Po0_rail1, Po1_rail1, Po2_rail1, Po3_rail1, Po4_rail1, Po5_rail1,
        input  Po0_rail0, Po1_rail0, Po2_rail0, Po3_rail0, Po4_rail0, Po5_rail0,
        input  out_ready,
        output Ki, out_valid, out_data, err_illegal, level
    );

    modport slave (
        output Po0_rail1, Po1_rail1, Po2_rail1, Po3_rail1, Po4_rail1, Po5_rail1,
        output Po0_rail0, Po1_rail0, Po2_rail0, Po3_rail0, Po4_rail0, Po5_rail0,
        output out_ready,
        input  Ki, out_valid, out_data, err_illegal, level
    );
endinterface

// File: rtl/ncl_prod_collector.sv
// Synchronises the NCL_MULT3 dual-rail product, runs the DATA/NULL
// handshake via Ki and queues decoded products in a small FIFO.
module ncl_prod_collector #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ncl_prod_collector_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(SETTLE + 1) + 1;

    localparam logic [1:0] ST_WAIT_NULL = 2'd0;
    localparam logic [1:0] ST_HOLD      = 2'd1;
    localparam logic [1:0] ST_REQ_DATA  = 2'd2;

    // rails packed as {rail1[5:0], rail0[5:0]}
    logic [11:0] raw_rails;
    assign raw_rails = {bus.Po5_rail1, bus.Po4_rail1, bus.Po3_rail1,
                        bus.Po2_rail1, bus.Po1_rail1, bus.Po0_rail1,
                        bus.Po5_rail0, bus.Po4_rail0, bus.Po3_rail0,
                        bus.Po2_rail0, bus.Po1_rail0, bus.Po0_rail0};

    logic [SYNC_STAGES-1:0][11:0] sync_q, sync_d;
    logic [11:0]                  prev_q, prev_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [1:0]                   state_q, state_d;
    logic                         err_q, err_d;
    logic [DEPTH-1:0][5:0]        mem_q, mem_d;
    logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]                level_q, level_d;

    logic [11:0] synced;
    logic [5:0]  syn_r1, syn_r0;
    logic        complete, empty, illegal, settled, has_space;
    logic        push, pop;

    assign synced    = sync_q[SYNC_STAGES-1];
    assign syn_r1    = synced[11:6];
    assign syn_r0    = synced[5:0];
    assign complete  = &(syn_r1 ^ syn_r0);
    assign empty     = ~|(syn_r1 | syn_r0);
    assign illegal   = |(syn_r1 & syn_r0);
    assign has_space = level_q < LW'(DEPTH);
    assign pop       = (level_q != '0) && bus.out_ready;

    always_comb begin
        sync_d[0] = raw_rails;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Settled is judged on the next count so a word that just changed
    // can never ride on the count left over from the previous pattern.
    always_comb begin
        prev_d = synced;
        cnt_d  = '0;
        if (!illegal && (synced == prev_q)) begin
            cnt_d = (cnt_q >= CW'(SETTLE)) ? cnt_q : cnt_q + 1'b1;
        end
        settled = (cnt_d >= CW'(SETTLE));
        err_d   = err_q | illegal;
    end

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            ST_WAIT_NULL: begin
                if (empty && settled) begin
                    state_d = has_space ? ST_REQ_DATA : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (has_space) begin
                    state_d = ST_REQ_DATA;
                end
            end
            ST_REQ_DATA: begin
                // space was reserved on entry, so this push cannot overflow
                if (complete && settled) begin
                    push    = 1'b1;
                    state_d = ST_WAIT_NULL;
                end
            end
            default: state_d = ST_WAIT_NULL;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = syn_r1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            state_q  <= ST_WAIT_NULL;
            err_q    <= 1'b0;
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            err_q    <= err_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign bus.Ki          = (state_q == ST_REQ_DATA);
    assign bus.out_valid   = (level_q != '0);
    assign bus.out_data    = (level_q != '0) ? mem_q[rd_ptr_q] : 6'd0;
    assign bus.err_illegal = err_q;
    assign bus.level       = level_q;
endmodule

// File: tb/tb_ncl_prod_collector.sv
// Directed/randomised bench for ncl_prod_collector: expected products are
// computed as a*b and queued; every pop is compared against that queue.
module tb_ncl_prod_collector;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ncl_prod_collector_if #(.DEPTH(DEPTH)) bus ();

    ncl_prod_collector #(.DEPTH(DEPTH), .SYNC_STAGES(2), .SETTLE(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_pops  = 0;
    logic [5:0] expq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic set_rails(input logic [5:0] r1, input logic [5:0] r0);
        bus.Po0_rail1 = r1[0]; bus.Po1_rail1 = r1[1]; bus.Po2_rail1 = r1[2];
        bus.Po3_rail1 = r1[3]; bus.Po4_rail1 = r1[4]; bus.Po5_rail1 = r1[5];
        bus.Po0_rail0 = r0[0]; bus.Po1_rail0 = r0[1]; bus.Po2_rail0 = r0[2];
        bus.Po3_rail0 = r0[3]; bus.Po4_rail0 = r0[4]; bus.Po5_rail0 = r0[5];
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ki(input logic exp, input string tag);
        for (int i = 0; i < 64; i++) begin
            if (bus.Ki === exp) break;
            step(1);
        end
        chk(tag, 32'(bus.Ki), 32'(exp));
    endtask

    // one DATA/NULL handshake carrying a*b
    task automatic send(input logic [5:0] v, input string tag);
        wait_ki(1'b1, {tag, "_req"});
        set_rails(v, ~v);
        expq.push_back(v);
        wait_ki(1'b0, {tag, "_ack"});
        set_rails(6'd0, 6'd0);
    endtask

    task automatic pop_one;
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
    endtask

    // scoreboard: every accepted head must be the oldest expected product
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            e = (expq.size() != 0) ? 32'(expq.pop_front()) : 32'hDEAD;
            chk("pop_data", 32'(bus.out_data), e);
            n_pops++;
        end
    end

    initial begin
        int pops0;
        logic [5:0] v;
        bus.out_ready = 1'b0;
        set_rails(6'($urandom), 6'($urandom));

        // reset with arbitrary rails
        step(1);
        chk("rst_ki",    32'(bus.Ki), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_err",   32'(bus.err_illegal), 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_data",  32'(bus.out_data), 0);
        step(2);
        rst = 1'b0;
        set_rails(6'd0, 6'd0);

        // single product 5*4
        send(6'(5 * 4), "single");
        step(1);
        chk("single_level", 32'(bus.level), 1);
        chk("single_valid", 32'(bus.out_valid), 1);
        chk("single_data",  32'(bus.out_data), 32'd20);
        set_rails(6'(5 * 4), ~6'(5 * 4));
        step(8);
        chk("single_ki_held", 32'(bus.Ki), 0);
        set_rails(6'd0, 6'd0);
        wait_ki(1'b1, "single_null_ki");
        pop_one();
        chk("single_empty", 32'(bus.level), 0);

        // stream with out_ready held high
        pops0 = n_pops;
        bus.out_ready = 1'b1;
        send(6'd20, "s20");
        send(6'd42, "s42");
        send(6'd7,  "s7");
        for (int k = 0; k < 3; k++) begin
            send(6'($urandom_range(0, 7) * $urandom_range(0, 7)), "srand");
        end
        step(6);
        chk("stream_pops",  32'(n_pops - pops0), 6);
        chk("stream_queue", 32'(expq.size()), 0);
        chk("stream_level", 32'(bus.level), 0);
        bus.out_ready = 1'b0;

        // backpressure: fill, park in HOLD, free one slot
        for (int k = 0; k < DEPTH; k++) begin
            send(6'($urandom_range(0, 7) * $urandom_range(0, 7)), "bp");
        end
        step(12);
        chk("bp_level",  32'(bus.level), DEPTH);
        chk("bp_hold",   32'(bus.Ki), 0);
        chk("bp_valid",  32'(bus.out_valid), 1);
        chk("bp_head",   32'(bus.out_data), 32'(expq[0]));
        pop_one();
        send(6'($urandom_range(0, 7) * $urandom_range(0, 7)), "bp5");
        step(1);
        chk("bp5_level", 32'(bus.level), DEPTH);
        bus.out_ready = 1'b1;
        step(8);
        chk("bp_drain",  32'(expq.size()), 0);
        chk("bp_drain_level", 32'(bus.level), 0);
        bus.out_ready = 1'b0;

        // glitch: complete pattern for a single cycle
        wait_ki(1'b1, "glitch_req");
        set_rails(6'b110011, 6'b001100);
        step(1);
        set_rails(6'd0, 6'd0);
        step(10);
        chk("glitch_level", 32'(bus.level), 0);
        chk("glitch_ki",    32'(bus.Ki), 1);

        // illegal bit 3, then a legal word
        set_rails(6'b101010 | 6'b001000, 6'b010101 | 6'b001000);
        step(12);
        chk("ill_err",   32'(bus.err_illegal), 1);
        chk("ill_level", 32'(bus.level), 0);
        chk("ill_ki",    32'(bus.Ki), 1);
        v = 6'(6 * 7);
        set_rails(v, ~v);
        expq.push_back(v);
        wait_ki(1'b0, "ill_recover_ack");
        set_rails(6'd0, 6'd0);
        step(1);
        chk("ill_sticky", 32'(bus.err_illegal), 1);
        chk("ill_head",   32'(bus.out_data), 32'(v));
        pop_one();

        // reset mid-handshake with a partial word and a queued entry
        send(6'(3 * 5), "mr");
        wait_ki(1'b1, "mr_req");
        set_rails(6'b000101, 6'b000010);
        step(4);
        rst = 1'b1;
        step(1);
        chk("mr_ki",    32'(bus.Ki), 0);
        chk("mr_valid", 32'(bus.out_valid), 0);
        chk("mr_level", 32'(bus.level), 0);
        chk("mr_data",  32'(bus.out_data), 0);
        chk("mr_err",   32'(bus.err_illegal), 0);
        expq.delete();
        rst = 1'b0;
        set_rails(6'd0, 6'd0);
        send(6'(7 * 7), "post");
        step(1);
        chk("post_level", 32'(bus.level), 1);
        pop_one();
        chk("post_empty", 32'(bus.level), 0);
        chk("post_queue", 32'(expq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
